mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 132 +++++++++++++
 tb/tb_mul_div_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// 8-bit sequential multiply/divide unit: shift-add MUL, restoring DIV/MOD,
// one iteration per clock, IDLE -> CALC -> DONE handshake for the register file.
module mul_div_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] OP,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE,
  output logic       C_FLAG,
  output logic       Z_FLAG,
  output logic       DIV0
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [1:0]  r_op;
  logic [2:0]  r_cnt;
  logic [7:0]  r_hi;
  logic [7:0]  r_lo;
  logic [7:0]  r_result;
  logic        r_busy;
  logic        r_done;
  logic        r_cflag;
  logic        r_div0;

  logic [8:0]  w_mul_sum;
  logic [8:0]  w_shl;
  logic [8:0]  w_diff;
  logic        w_q;
  logic [7:0]  w_hi_nx;
  logic [7:0]  w_lo_nx;

  // {r_hi,r_lo}: MUL holds partial product / remaining multiplier,
  // DIV holds partial remainder / dividend shifting into quotient.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : 9'd0);
    w_shl     = {r_hi, r_lo[7]};
    w_diff    = w_shl - {1'b0, r_b};
    w_q       = (w_shl >= {1'b0, r_b});
    if (!r_op[1]) begin
      w_hi_nx = w_mul_sum[8:1];
      w_lo_nx = {w_mul_sum[0], r_lo[7:1]};
    end else begin
      w_hi_nx = w_q ? w_diff[7:0] : w_shl[7:0];
      w_lo_nx = {r_lo[6:0], w_q};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_a      <= 8'd0;
      r_b      <= 8'd0;
      r_op     <= 2'd0;
      r_cnt    <= 3'd0;
      r_hi     <= 8'd0;
      r_lo     <= 8'd0;
      r_result <= 8'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cflag  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (START) begin
            r_a   <= A;
            r_b   <= B;
            r_op  <= OP;
            r_cnt <= 3'd0;
            if (OP[1] && (B == 8'd0)) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_div0   <= 1'b1;
              r_cflag  <= 1'b1;
              r_result <= OP[0] ? A : 8'hFF;
            end else begin
              r_state <= S_CALC;
              r_busy  <= 1'b1;
              r_div0  <= 1'b0;
              r_hi    <= 8'd0;
              r_lo    <= OP[1] ? A : B;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nx;
          r_lo  <= w_lo_nx;
          r_cnt <= r_cnt + 3'd1;
          // Eighth iteration: publish the result as DONE is entered.
          if (r_cnt == 3'd7) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= r_op[0] ? w_hi_nx : w_lo_nx;
            r_cflag  <= r_op[1] ? 1'b0 : (w_hi_nx != 8'd0);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign RESULT = r_result;
  assign BUSY   = r_busy;
  assign DONE   = r_done;
  assign C_FLAG = r_cflag;
  assign DIV0   = r_div0;
  // Derived from the registered result so it reads 1 straight out of reset.
  assign Z_FLAG = (r_result == 8'd0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes model results, monitor pops on DONE.
module tb_mul_div_unit;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [1:0] OP;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;
  logic       C_FLAG;
  logic       Z_FLAG;
  logic       DIV0;

  mul_div_unit dut (
    .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
    .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE), .C_FLAG(C_FLAG),
    .Z_FLAG(Z_FLAG), .DIV0(DIV0)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       d0;
    int         busy;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;
  bit   hold_chk = 0;
  logic [7:0] last_res = 8'd0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   p;
    p    = int'(a) * int'(b);
    e.d0 = 1'b0;
    e.busy = 8;
    case (op)
      2'd0: begin e.res = 8'(p % 256); e.c = (p > 255); end
      2'd1: begin e.res = 8'(p / 256); e.c = (p > 255); end
      default: begin
        if (b == 0) begin
          e.res  = (op == 2'd2) ? 8'hFF : a;
          e.d0   = 1'b1;
          e.c    = 1'b1;
          e.busy = 0;
        end else begin
          e.res = (op == 2'd2) ? 8'(int'(a) / int'(b)) : 8'(int'(a) % int'(b));
          e.c   = 1'b0;
        end
      end
    endcase
    e.z = (e.res == 8'd0);
    return e;
  endfunction

  // Monitor: compares on every DONE, independent of the driver.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      busy_cnt = 0;
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        check("hold_result", int'(RESULT), int'(last_res));
        hold_chk = 0;
      end
      if (BUSY) busy_cnt++;
      if (DONE) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got DONE=1 expected no pending op (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          check("result", int'(RESULT), int'(e.res));
          check("c_flag", int'(C_FLAG), int'(e.c));
          check("z_flag", int'(Z_FLAG), int'(e.z));
          check("div0",   int'(DIV0),   int'(e.d0));
          check("busy_cycles", busy_cnt, e.busy);
          last_res = e.res;
          hold_chk = 1;
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input bit hold);
    bit seen;
    q.push_back(model(op, a, b));
    START = 1'b1; OP = op; A = a; B = b;
    @(posedge CLK); #1;
    if (!hold) START = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) seen = 1;
      else if (hold) begin
        A  = 8'($urandom);
        B  = 8'($urandom);
        OP = 2'($urandom);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no DONE expected DONE within 20 cycles");
      void'(q.pop_front());
    end
    START = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rop;
    RST = 1'b1; START = 1'b0; OP = 2'd0; A = 8'd0; B = 8'd0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_result", int'(RESULT), 0);
    check("rst_busy",   int'(BUSY),   0);
    check("rst_done",   int'(DONE),   0);
    check("rst_c",      int'(C_FLAG), 0);
    check("rst_div0",   int'(DIV0),   0);
    check("rst_z",      int'(Z_FLAG), 1);
    @(posedge CLK); #1;

    issue(2'd0, 8'd13,  8'd11,  0);
    issue(2'd1, 8'd200, 8'd200, 0);
    issue(2'd0, 8'd200, 8'd200, 0);
    issue(2'd2, 8'd100, 8'd7,   0);
    issue(2'd3, 8'd100, 8'd7,   0);
    issue(2'd3, 8'd6,   8'd3,   0);
    issue(2'd2, 8'd5,   8'd0,   0);
    issue(2'd3, 8'd5,   8'd0,   0);
    issue(2'd1, 8'd255, 8'd255, 1);
    issue(2'd2, 8'd255, 8'd1,   1);
    issue(2'd3, 8'd0,   8'd0,   0);

    // Abort mid-CALC: reset sampled on the fourth iteration edge.
    q.push_back(model(2'd0, 8'd77, 8'd91));
    START = 1'b1; OP = 2'd0; A = 8'd77; B = 8'd91;
    @(posedge CLK); #1 START = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    void'(q.pop_back());
    @(negedge CLK);
    check("abort_result", int'(RESULT), 0);
    check("abort_busy",   int'(BUSY),   0);
    check("abort_done",   int'(DONE),   0);
    check("abort_c",      int'(C_FLAG), 0);
    check("abort_div0",   int'(DIV0),   0);
    check("abort_z",      int'(Z_FLAG), 1);
    repeat (12) @(negedge CLK);
    @(posedge CLK); #1;
    issue(2'd2, 8'd200, 8'd13, 0);

    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom);
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(rop, ra, rb, bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge CLK);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
